// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and constants for the APB subsystem: master FSM
//               state encoding, default bus widths and pwrite encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Master FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Default command / APB address and data widths
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    // pwrite encodings
    localparam logic APB_WRITE = 1'b1;
    localparam logic APB_READ  = 1'b0;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_mem
// Description : APB slave backed by a byte-wide register memory. Produces
//               pready/pslaverr combinationally and registers read data.
//               Optional macro APB_WAIT_STATE_EN inserts one wait state per
//               transfer (pready low in the first ACCESS cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = APB_ADDR_W,
    parameter int DATA_W    = APB_DATA_W
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic              pslaverr,
    output logic [DATA_W-1:0] prdata
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // Depth widened by one bit so MEM_DEPTH = 256 still compares correctly
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] prdata_q;
    logic [DATA_W-1:0] prdata_d;
    logic [IDX_W-1:0]  mem_idx;
    logic              access;
    logic              out_of_range;
    logic              mem_we;

`ifdef APB_WAIT_STATE_EN
    logic wait_done_q;
    logic wait_done_d;

    // First ACCESS cycle arms the flag; the second cycle completes and clears it
    always_comb begin
        wait_done_d = psel & penable & ~wait_done_q;
    end

    // Wait-state flag register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_done_q <= 1'b0;
        end else begin
            wait_done_q <= wait_done_d;
        end
    end

    assign access = psel & penable & wait_done_q;
`else
    assign access = psel & penable;
`endif

    assign mem_idx      = paddr[IDX_W-1:0];
    assign out_of_range = ({1'b0, paddr} >= DEPTH_EXT);
    assign pready       = access;
    // Error is only meaningful in the completing cycle, so gate it with pready
    assign pslaverr     = access & out_of_range;
    assign prdata       = prdata_q;

    // Commit/capture decisions for the completing ACCESS cycle
    always_comb begin
        mem_we   = 1'b0;
        prdata_d = prdata_q;
        if (access && !out_of_range) begin
            if (pwrite == APB_WRITE) begin
                mem_we = 1'b1;
            end else begin
                prdata_d = mem_q[mem_idx];
            end
        end
    end

    // Memory array and read-data register; reset clears every entry
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            prdata_q <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            prdata_q <= prdata_d;
            if (mem_we) begin
                mem_q[mem_idx] <= pwdata;
            end
        end
    end

endmodule : apb_slave_mem
`default_nettype wire

// File: rtl/apb_topmodule.sv
`default_nettype none
// ============================================================================
// Module      : apb_topmodule
// Description : Self-contained APB subsystem. A master FSM turns a simple
//               command interface into APB SETUP/ACCESS phases towards a
//               single memory-backed slave (apb_slave_mem). Only pready,
//               pslaverr and prdata are visible outside.
//               Optional macro APB_WAIT_STATE_EN (slave wait state).
// Revision    : 1.0 - initial release
// ============================================================================
module apb_topmodule
    import apb_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = APB_ADDR_W,
    parameter int DATA_W    = APB_DATA_W
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              transfer,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] apb_write_paddr,
    input  logic [ADDR_W-1:0] apb_read_paddr,
    input  logic [DATA_W-1:0] apb_write_data,
    output logic              pready,
    output logic              pslaverr,
    output logic [DATA_W-1:0] prdata
);

    apb_state_e        state_q,  state_d;
    logic              psel_q,   psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q,  paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              latch_cmd;

    // Next-state and command-latch decisions; bus controls follow the next state
    always_comb begin
        state_d   = state_q;
        latch_cmd = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d   = SETUP;
                    latch_cmd = 1'b1;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    if (transfer) begin
                        state_d   = SETUP;
                        latch_cmd = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);

        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        if (latch_cmd) begin
            pwrite_d = read_write;
            paddr_d  = (read_write == APB_WRITE) ? apb_write_paddr : apb_read_paddr;
            pwdata_d = apb_write_data;
        end
    end

    // Master FSM state, registered bus controls and latched command
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= APB_READ;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    apb_slave_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) u_slave (
        .pclk     (pclk),
        .presetn  (presetn),
        .psel     (psel_q),
        .penable  (penable_q),
        .pwrite   (pwrite_q),
        .paddr    (paddr_q),
        .pwdata   (pwdata_q),
        .pready   (pready),
        .pslaverr (pslaverr),
        .prdata   (prdata)
    );

endmodule : apb_topmodule
`default_nettype wire

// File: tb/tb_apb_topmodule.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_topmodule
// Description : Directed self-checking bench for apb_topmodule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_topmodule;

`ifdef APB_WAIT_STATE_EN
    localparam int EXP_WAIT = 1;
`else
    localparam int EXP_WAIT = 0;
`endif
    localparam int MEM_DEPTH = 64;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       transfer;
    logic       read_write;
    logic [7:0] apb_write_paddr;
    logic [7:0] apb_read_paddr;
    logic [7:0] apb_write_data;
    logic       pready;
    logic       pslaverr;
    logic [7:0] prdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_mem [256];
    logic [7:0] exp_prdata;

    apb_topmodule #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(8), .DATA_W(8)) dut (
        .pclk            (pclk),
        .presetn         (presetn),
        .transfer        (transfer),
        .read_write      (read_write),
        .apb_write_paddr (apb_write_paddr),
        .apb_read_paddr  (apb_read_paddr),
        .apb_write_data  (apb_write_data),
        .pready          (pready),
        .pslaverr        (pslaverr),
        .prdata          (prdata)
    );

    always #5 pclk = ~pclk;

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        exp_prdata = 8'h00;
    endfunction

    // One transfer. Called at a negedge where the FSM is IDLE or in a completing
    // ACCESS cycle; returns at the negedge of this transfer's completing cycle.
    task automatic run_xfer(input logic rw, input logic [7:0] addr, input logic [7:0] data);
        int  waits;
        logic exp_err;
        exp_err         = (addr >= MEM_DEPTH);
        transfer        = 1'b1;
        read_write      = rw;
        apb_write_paddr = rw ? addr : 8'hEE;
        apb_read_paddr  = rw ? 8'hEE : addr;
        apb_write_data  = data;
        @(posedge pclk); @(negedge pclk);
        // SETUP cycle: no completion yet; previous read result visible
        n_checks++;
        if (pready !== 1'b0) begin
            n_fail++; $display("FAIL setup_pready addr=%02h got=%b exp=0", addr, pready);
        end
        n_checks++;
        if (prdata !== exp_prdata) begin
            n_fail++; $display("FAIL setup_prdata addr=%02h got=%02h exp=%02h", addr, prdata, exp_prdata);
        end
        // Disturb command inputs mid-transfer; they must be ignored
        transfer        = 1'b0;
        read_write      = ~rw;
        apb_write_paddr = ~addr;
        apb_read_paddr  = ~addr;
        apb_write_data  = ~data;
        waits = 0;
        @(posedge pclk); @(negedge pclk);
        while (pready !== 1'b1 && waits < 4) begin
            waits++;
            @(posedge pclk); @(negedge pclk);
        end
        n_checks++;
        if (waits != EXP_WAIT) begin
            n_fail++; $display("FAIL wait_states addr=%02h got=%0d exp=%0d", addr, waits, EXP_WAIT);
        end
        n_checks++;
        if (pslaverr !== exp_err) begin
            n_fail++; $display("FAIL pslaverr addr=%02h got=%b exp=%b", addr, pslaverr, exp_err);
        end
        n_checks++;
        if (prdata !== exp_prdata) begin
            n_fail++; $display("FAIL early_prdata addr=%02h got=%02h exp=%02h", addr, prdata, exp_prdata);
        end
        if (!exp_err) begin
            if (rw) model_mem[addr] = data;
            else    exp_prdata      = model_mem[addr];
        end
    endtask

    // Drop transfer after a completion and verify FSM settles idle
    task automatic go_idle();
        transfer = 1'b0;
        repeat (3) begin
            @(posedge pclk); @(negedge pclk);
            n_checks++;
            if (pready !== 1'b0 || pslaverr !== 1'b0) begin
                n_fail++; $display("FAIL idle_outputs got=%b%b exp=00", pready, pslaverr);
            end
        end
        n_checks++;
        if (prdata !== exp_prdata) begin
            n_fail++; $display("FAIL idle_prdata got=%02h exp=%02h", prdata, exp_prdata);
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        transfer = 1'b0; read_write = 1'b0;
        apb_write_paddr = 8'h00; apb_read_paddr = 8'h00; apb_write_data = 8'h00;
        model_reset();
        @(negedge pclk);
        presetn = 1'b1;
        n_checks++;
        if (prdata !== 8'h00 || pready !== 1'b0 || pslaverr !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs got=%02h/%b/%b exp=00/0/0", prdata, pready, pslaverr);
        end
        run_xfer(1'b0, 8'h05, 8'h00);
        go_idle();
    endtask

    task automatic test_write_read();
        run_xfer(1'b1, 8'h15, 8'hA5);
        run_xfer(1'b0, 8'h15, 8'h00);
        go_idle();
        n_checks++;
        if (prdata !== 8'hA5) begin
            n_fail++; $display("FAIL write_read got=%02h exp=a5", prdata);
        end
    endtask

    task automatic test_back_to_back();
        run_xfer(1'b1, 8'h20, 8'hB5);
        run_xfer(1'b0, 8'h20, 8'h00);
        run_xfer(1'b1, 8'h30, 8'h65);
        run_xfer(1'b0, 8'h30, 8'h00);
        go_idle();
        n_checks++;
        if (prdata !== 8'h65) begin
            n_fail++; $display("FAIL b2b_final got=%02h exp=65", prdata);
        end
    endtask

    task automatic test_error();
        run_xfer(1'b1, 8'h50, 8'h11);   // out of range: dropped
        run_xfer(1'b0, 8'h50, 8'h00);   // out of range: prdata unchanged
        run_xfer(1'b1, 8'h3F, 8'h9C);   // last valid entry
        run_xfer(1'b1, 8'h40, 8'h22);   // first invalid entry
        run_xfer(1'b0, 8'h10, 8'h00);   // alias of 0x50 must still be 0
        run_xfer(1'b0, 8'h3F, 8'h00);
        go_idle();
        n_checks++;
        if (prdata !== 8'h9C) begin
            n_fail++; $display("FAIL boundary_read got=%02h exp=9c", prdata);
        end
    endtask

    task automatic test_reset_mid();
        transfer = 1'b1; read_write = 1'b1;
        apb_write_paddr = 8'h10; apb_write_data = 8'h7E;
        @(posedge pclk); @(negedge pclk);   // SETUP
        transfer = 1'b0;
        @(posedge pclk); @(negedge pclk);   // first ACCESS cycle
        presetn = 1'b0;
        #1;
        n_checks++;
        if (pready !== 1'b0 || prdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_mid_outputs got=%b/%02h exp=0/00", pready, prdata);
        end
        model_reset();
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk); @(negedge pclk);
        n_checks++;
        if (pready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_idle got=%b exp=0", pready);
        end
        run_xfer(1'b0, 8'h10, 8'h00);
        go_idle();
        n_checks++;
        if (prdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_mid_read got=%02h exp=00", prdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_error();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_apb_topmodule
`default_nettype wire

// File: doc/apb_topmodule.md
Name: apb_topmodule

Overview:
- Self-contained APB subsystem: an APB master FSM driven by a simple command interface (transfer, read_write, addresses, write data), wired internally to a single APB slave backed by a byte-wide register memory.
- Used as a protocol demonstrator and a bus-level building block.
- Exposes only the completion handshake (pready), the error flag and the read data.

Parameters:
- MEM_DEPTH, 64, number of 8-bit slave memory entries. Valid addresses are 0 .. MEM_DEPTH-1; must be ≤ 256.
- ADDR_W, 8, command and APB address width.
- DATA_W, 8, data width.

Ports:
- pclk  in  1  rising-edge clock.
- presetn  in  1  asynchronous active-low reset.
- transfer  in  1  request a transfer. Sampled in IDLE and at ACCESS completion.
- read_write  in  1  1 = write, 0 = read. Latched on entry to SETUP.
- apb_write_paddr  in  8  write address. Latched on SETUP entry when read_write=1.
- apb_read_paddr  in  8  read address. Latched on SETUP entry when read_write=0.
- apb_write_data  in  8  write data. Latched on SETUP entry.
- pready  out  1  slave ready. High in the ACCESS cycle that completes the transfer.
- pslaverr  out  1  slave error. Valid only when pready=1.
- prdata  out  8  registered read data of the last successful read.

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE.
  - Internal psel/penable/pwrite are 0; latched address and data are 0.
  - prdata=0, pready=0, pslaverr=0.
  - All memory entries are cleared to 0x00.
  - Reset asserted mid-transfer aborts the transfer with no memory update.
- FSM states and transitions:
  - IDLE: psel=0, penable=0. If transfer=1, go to SETUP at the next edge and latch the command on that edge.
  - SETUP: psel=1, penable=0. Unconditionally go to ACCESS at the next edge.
  - ACCESS: psel=1, penable=1. Hold while pready=0. When pready=1: go to SETUP if transfer=1 (re-latching the command on that edge), else go to IDLE.
- Command latching on SETUP entry:
  - pwrite = read_write.
  - paddr = apb_write_paddr if read_write=1, else apb_read_paddr.
  - pwdata = apb_write_data.
- Command inputs are ignored outside these latch edges; changing them mid-transfer has no effect.
- Throughput: back-to-back transfers take 2 cycles each (SETUP + ACCESS) with zero wait states.
- Slave pready: combinational, pready = psel & penable (zero-wait slave).
- Slave pslaverr: combinational, = psel & penable & (paddr ≥ MEM_DEPTH). Forced 0 outside ACCESS.
- Write: memory[paddr] <= pwdata at the completing ACCESS edge, when pwrite=1 and pslaverr=0. Erroneous writes are dropped.
- Read: prdata <= memory[paddr] at the completing ACCESS edge, when pwrite=0 and pslaverr=0.
  - prdata is valid from the cycle after ACCESS and holds until the next successful read.
  - An erroneous read leaves prdata unchanged.
- Read-after-write to the same address in consecutive transfers returns the new data (the write commits before the read's ACCESS).

Optional Feature:
- Macro: APB_WAIT_STATE_EN.
- Defined: the slave inserts exactly one wait state per transfer.
  - pready=0 in the first ACCESS cycle and 1 in the second; each transfer takes 3 cycles.
  - pslaverr is evaluated only when pready=1.
- Undefined: zero-wait behaviour as specified above.

Decomposition:
- Package apb_pkg holds:
  - the state typedef (IDLE, SETUP, ACCESS);
  - ADDR_W and DATA_W defaults;
  - localparam encodings for pwrite (APB_WRITE=1, APB_READ=0).
- One sub-module, apb_slave_mem: holds the memory array and the pready/pslaverr/prdata logic, plus the optional wait-state counter.
- The master FSM and command latching stay in the top.

Test Plan:
- Reset held 1 cycle, then released:
  - prdata=0x00, pready=0, pslaverr=0.
  - A read of address 0x05 returns 0x00.
- Write then read:
  - transfer=1, read_write=1, addr 0x15, data 0xA5, followed immediately by read addr 0x15.
  - pready pulses once per 2 cycles; prdata=0xA5 the cycle after the read's ACCESS.
- Back-to-back sequence with transfer held high: writes 0x20←0xB5 and 0x30←0x65, each followed by a read of the same address.
  - prdata sequence is 0xB5 then 0x65; no IDLE states between transfers.
  - Deasserting transfer afterwards returns the FSM to IDLE, and prdata holds 0x65.
- Error path: write addr 0x50 (≥ 64) with data 0x11.
  - pslaverr=1 with pready=1; memory unchanged.
  - A subsequent read of addr 0x50 gives pslaverr=1 and prdata keeps its previous value.
- Reset mid-transfer: assert presetn=0 during the ACCESS cycle of a write 0x10←0x7E.
  - FSM goes to IDLE; a later read of 0x10 returns 0x00.
- With APB_WAIT_STATE_EN defined: write 0x15←0xA5 then read 0x15.
  - Each transfer takes 3 cycles, with pready low in the first ACCESS cycle.
  - prdata=0xA5.
